// File: rtl/manchester_frame_deframer.sv
// -----------------------------------------------------------------------------
// manchester_frame_deframer
//
// Bit-to-word framing stage behind the Manchester decoder. One decoded bit is
// sampled per recovered_clk rising edge. The block hunts for SYNC_PATTERN,
// then assembles WORDS_PER_FRAME words of DATA_W bits (MSB first) and queues
// them, tagged with a last-word flag, in a show-ahead FIFO.
//
// Optional feature macro: PARITY_CHECK_EN
//   defined   : each word is followed by one even-parity bit; a bad word is
//               dropped, parity_err pulses and the frame is aborted.
//   undefined : no parity bit, parity_err is tied to 0.
//
// Ports:
//   recovered_clk  in   bit clock
//   rst_n          in   asynchronous active-low reset
//   rx_bit         in   decoded serial data
//   out_data       out  head-of-FIFO word (0 when the FIFO is empty)
//   out_last       out  head word is the final word of its frame
//   out_valid      out  FIFO not empty
//   out_ready      in   consumer accepts the head word
//   locked         out  inside a frame (DATA / PARITY)
//   parity_err     out  one-cycle pulse on a parity failure
//   overflow       out  sticky: a word was dropped on a full FIFO
//   clr_ovf        in   synchronous clear for overflow
//   fifo_level     out  FIFO occupancy
// -----------------------------------------------------------------------------
module manchester_frame_deframer #(
    parameter int          DATA_W          = 8,
    parameter int          SYNC_W          = 8,
    parameter logic [15:0] SYNC_PATTERN    = 16'h00D5,
    parameter int          WORDS_PER_FRAME = 4,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic                          recovered_clk,
    input  logic                          rst_n,
    input  logic                          rx_bit,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          locked,
    output logic                          parity_err,
    output logic                          overflow,
    input  logic                          clr_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BIT_CW = $clog2(DATA_W);
    localparam int WCNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
`ifdef PARITY_CHECK_EN
    // The whole word is held until the parity bit arrives.
    localparam int WREG_W = DATA_W;
`else
    // The final data bit is taken straight from rx_bit at the push edge.
    localparam int WREG_W = DATA_W - 1;
`endif

    localparam logic [SYNC_W-1:0] SYNC_VAL  = SYNC_W'(SYNC_PATTERN);
    localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(DATA_W - 1);
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WORDS_PER_FRAME - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_HUNT,
`ifdef PARITY_CHECK_EN
        ST_PARITY,
`endif
        ST_DATA
    } state_e;

    state_e              state_q, state_d;
    // Only the SYNC_W-1 most recent bits are stored; rx_bit completes the window.
    logic [SYNC_W-2:0]   shreg_q, shreg_d;
    logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WREG_W-1:0]   word_q, word_d;
    logic                parity_err_q, parity_err_d;
    logic                overflow_q, overflow_d;

    logic [DATA_W:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;

    logic                push;
    logic [DATA_W-1:0]   push_word;
    logic                push_last;
    logic                pop;
    logic                full;
    logic                push_ok;
    logic                ovf_set;
    logic [DATA_W:0]     head;

    // -------------------------------------------------------------------------
    // Framing state machine
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block free of latches.
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        word_d       = word_q;
        parity_err_d = 1'b0;
        push         = 1'b0;
        push_word    = '0;
        push_last    = (word_cnt_q == WORD_LAST);

        case (state_q)
            ST_HUNT: begin
                shreg_d = (SYNC_W-1)'({shreg_q, rx_bit});
                if ({shreg_q, rx_bit} == SYNC_VAL) begin
                    state_d    = ST_DATA;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end

            ST_DATA: begin
                word_d    = WREG_W'({word_q, rx_bit});
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
`ifdef PARITY_CHECK_EN
                    state_d = ST_PARITY;
`else
                    push      = 1'b1;
                    push_word = {word_q, rx_bit};
`endif
                end
            end

`ifdef PARITY_CHECK_EN
            ST_PARITY: begin
                if (^{word_q, rx_bit} == 1'b0) begin
                    push      = 1'b1;
                    push_word = word_q;
                end else begin
                    // Abort the frame; the remaining bits are hunted afresh.
                    parity_err_d = 1'b1;
                    state_d      = ST_HUNT;
                    shreg_d      = '0;
                end
            end
`endif

            default: begin
                state_d = ST_HUNT;
                shreg_d = '0;
            end
        endcase

        // The frame advances on every push, even one the FIFO has to drop.
        if (push) begin
            word_cnt_d = word_cnt_q + 1'b1;
            bit_cnt_d  = '0;
            if (push_last) begin
                state_d = ST_HUNT;
                shreg_d = '0;
            end else begin
                state_d = ST_DATA;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO control
    // -------------------------------------------------------------------------
    always_comb begin
        pop      = out_valid && out_ready;
        full     = (level_q == LVL_FULL);
        // A pop on the same edge frees the slot a full FIFO needs.
        push_ok  = push && (!full || pop);
        ovf_set  = push && full && !pop;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Set wins over a simultaneous clear.
        overflow_d = ovf_set || (overflow_q && !clr_ovf);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written only with <= so every register samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge recovered_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            word_q       <= '0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            word_q       <= word_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only visible once the
    // level says it was written, and out_data is masked while empty.
    always_ff @(posedge recovered_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_last, push_word};
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? head[DATA_W-1:0] : '0;
    assign out_last   = out_valid && head[DATA_W];
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
`ifdef PARITY_CHECK_EN
    assign locked     = (state_q == ST_DATA) || (state_q == ST_PARITY);
    assign parity_err = parity_err_q;
`else
    assign locked     = (state_q == ST_DATA);
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_manchester_frame_deframer.sv
// -----------------------------------------------------------------------------
// tb_manchester_frame_deframer
//
// Drives bit streams into manchester_frame_deframer and compares every output
// after every edge with a frame-position reference model (bit position since
// sync, divided into words) and a queue standing in for the FIFO.
// Works with and without PARITY_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_manchester_frame_deframer;

    localparam int DATA_W = 8;
    localparam int SYNC_W = 8;
    localparam int SYNC   = 'hD5;
    localparam int WPF    = 4;
    localparam int DEPTH  = 4;
`ifdef PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int BPW = DATA_W + (PAR ? 1 : 0);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  rx_bit;
    logic [DATA_W-1:0]     out_data;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;
    logic                  locked;
    logic                  parity_err;
    logic                  overflow;
    logic                  clr_ovf;
    logic [$clog2(DEPTH):0] fifo_level;

    manchester_frame_deframer #(
        .DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_PATTERN(16'h00D5),
        .WORDS_PER_FRAME(WPF), .FIFO_DEPTH(DEPTH)
    ) dut (
        .recovered_clk(clk), .rst_n(rst_n), .rx_bit(rx_bit),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .locked(locked), .parity_err(parity_err),
        .overflow(overflow), .clr_ovf(clr_ovf), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_hunt;
    int m_hist;
    int m_pos;
    int m_acc;
    int mq[$];
    bit m_ovf;
    bit m_perr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hunt = 1'b1;
        m_hist = 0;
        m_pos  = 0;
        m_acc  = 0;
        mq.delete();
        m_ovf  = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic model_edge(input bit b, input bit rdy, input bit clr);
        bit pop  = (mq.size() != 0) && rdy;
        bit full = (mq.size() == DEPTH);
        bit push = 1'b0;
        bit last = 1'b0;
        int entry = 0;
        int k, widx;
        m_perr = 1'b0;
        if (m_hunt) begin
            m_hist = ((m_hist << 1) | int'(b)) & ((1 << SYNC_W) - 1);
            if (m_hist == SYNC) begin
                m_hunt = 1'b0;
                m_pos  = 0;
                m_acc  = 0;
            end
        end else begin
            k    = m_pos % BPW;
            widx = m_pos / BPW;
            m_pos++;
            if (k < DATA_W) m_acc = (m_acc << 1) | int'(b);
            if (!PAR && k == DATA_W - 1) begin
                push = 1'b1;
            end else if (PAR && k == DATA_W) begin
                if ((($countones(m_acc) + int'(b)) % 2) == 0) begin
                    push = 1'b1;
                end else begin
                    m_perr = 1'b1;
                    m_hunt = 1'b1;
                    m_hist = 0;
                end
            end
            if (push) begin
                last  = (widx == WPF - 1);
                entry = (int'(last) << DATA_W) | m_acc;
                m_acc = 0;
                if (last) begin
                    m_hunt = 1'b1;
                    m_hist = 0;
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (full && !pop) m_ovf = 1'b1;
            else mq.push_back(entry);
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        if (push && full && !pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic compare_all();
        check("valid",  out_valid,  mq.size() != 0);
        check("level",  fifo_level, mq.size());
        check("locked", locked,     !m_hunt);
        check("perr",   parity_err, m_perr);
        check("ovf",    overflow,   m_ovf);
        if (mq.size() != 0) begin
            check("data", out_data, mq[0] & ((1 << DATA_W) - 1));
            check("last", out_last, (mq[0] >> DATA_W) & 1);
        end
    endtask

    task automatic send_bit(input bit b, input bit rdy, input bit clr);
        @(negedge clk);
        rx_bit    = b;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        model_edge(b, rdy, clr);
        #1;
        compare_all();
    endtask

    // Ready policy: 0 never, 1 always, 2 random, 3 only on a word's final bit.
    function automatic bit pick_ready(input int policy, input bit final_bit);
        case (policy)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(0, 1));
            default: return final_bit;
        endcase
    endfunction

    task automatic send_val(input int v, input int n, input int policy);
        for (int i = n - 1; i >= 0; i--)
            send_bit(1'((v >> i) & 1), pick_ready(policy, i == 0), 1'b0);
    endtask

    task automatic send_word(input int w, input int policy, input bit bad);
        int p = ($countones(w) & 1) ^ int'(bad);
        if (PAR) send_val((w << 1) | p, BPW, policy);
        else     send_val(w, DATA_W, policy);
    endtask

    task automatic send_frame(input int w[WPF], input int policy, input int bad_idx);
        send_val(SYNC, SYNC_W, (policy == 3) ? 0 : policy);
        for (int i = 0; i < WPF; i++) send_word(w[i], policy, i == bad_idx);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},   out_data,   0);
        check({tag, "_last"},   out_last,   0);
        check({tag, "_valid"},  out_valid,  0);
        check({tag, "_locked"}, locked,     0);
        check({tag, "_perr"},   parity_err, 0);
        check({tag, "_ovf"},    overflow,   0);
        check({tag, "_level"},  fifo_level, 0);
    endtask

    int fr[WPF];

    initial begin
        rst_n = 1'b0; rx_bit = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame with the consumer always ready.
        fr = '{'h12, 'h34, 'h56, 'h78};
        send_frame(fr, 1, -1);
        send_val(0, 8, 1);

        // Noise before sync; sync pattern embedded inside the payload.
        send_val('hAB, 8, 1);
        send_val('hD4, 8, 1);
        fr = '{'hD5, 'h6A, 'hB5, 'h01};
        send_frame(fr, 1, -1);
        send_val(0, 4, 1);

        // Fill with no consumer, then overflow, clear and drain.
        fr = '{'h11, 'h22, 'h33, 'h44};
        send_frame(fr, 0, -1);
        check("fill_level", fifo_level, DEPTH);
        check("fill_ovf", overflow, 0);
        fr = '{'h55, 'h66, 'h77, 'h88};
        send_frame(fr, 0, -1);
        check("ovf_set", overflow, 1);
        check("ovf_level", fifo_level, DEPTH);
        send_bit(1'b0, 1'b0, 1'b1);
        check("ovf_clr", overflow, 0);
        check("drain_head", out_data, 'h11);
        send_val(0, 8, 1);
        check("drained", out_valid, 0);

        // Full FIFO with a pop on each push edge.
        fr = '{'h01, 'h02, 'h03, 'h04};
        send_frame(fr, 0, -1);
        fr = '{'hF1, 'hF2, 'hF3, 'hF4};
        send_frame(fr, 3, -1);
        check("pp_level", fifo_level, DEPTH);
        check("pp_ovf", overflow, 0);
        send_val(0, 8, 1);

`ifdef PARITY_CHECK_EN
        // Good parity accepted, bad parity aborts the frame.
        fr = '{'hA5, 'h3C, 'h0F, 'hF0};
        send_frame(fr, 1, -1);
        send_val(0, 4, 1);
        fr = '{'hA5, 'h3C, 'h0F, 'hF0};
        send_frame(fr, 1, 0);
        send_val(0, 4, 1);
`endif

        // Reset in the middle of a word.
        fr = '{'h9A, 'hBC, 'hDE, 'hF0};
        send_frame(fr, 0, -1);
        send_val(SYNC, SYNC_W, 0);
        send_val('h5, 3, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fr = '{'hC3, 'h5A, 'hE7, 'h18};
        send_frame(fr, 1, -1);
        send_val(0, 4, 1);

        // Randomized traffic: noise, random readiness, occasional clears.
        for (int it = 0; it < 40; it++) begin
            int nz = $urandom_range(0, 12);
            int bad = -1;
            for (int j = 0; j < nz; j++)
                send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 7) == 0);
            for (int j = 0; j < WPF; j++) fr[j] = int'($urandom_range(0, (1 << DATA_W) - 1));
            if (PAR && $urandom_range(0, 5) == 0) bad = int'($urandom_range(0, WPF - 1));
            send_frame(fr, 2, bad);
        end
        send_val(0, 16, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/manchester_frame_deframer.md
Name: manchester_frame_deframer

Overview:
- Bit-to-word framing stage that sits directly behind the Manchester decoder.
- Runs on the decoder's recovered clock and samples one decoded bit per rising edge.
- Hunts for a programmable sync pattern, then assembles a fixed number of DATA_W-bit words, MSB first.
- Optionally checks per-word even parity, and buffers accepted words in a small show-ahead FIFO with a valid/ready output handshake and a last-word flag.

Parameters:
- DATA_W, 8: bits per payload word (2..32).
- SYNC_W, 8: sync pattern length (2..16).
- SYNC_PATTERN, 8'hD5: sync word; the SYNC_W LSBs are used.
- WORDS_PER_FRAME, 4: words per frame after sync (>=1).
- FIFO_DEPTH, 4: FIFO entries; power of 2, >=2.

Ports:
- recovered_clk  input  1  Bit clock; one decoded bit per rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- rx_bit  input  1  Decoded serial data, stable at the recovered_clk rising edge.
- out_data  output  DATA_W  Head-of-FIFO word.
- out_last  output  1  Head word is the final word of its frame.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  Consumer accepts the head word.
- locked  output  1  High in the DATA and PARITY states.
- parity_err  output  1  One-cycle pulse on a parity failure.
- overflow  output  1  Sticky: a word was dropped because the FIFO was full.
- clr_ovf  input  1  Synchronous clear for overflow.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  Current FIFO occupancy.

Behaviour:
- Reset (async, rst_n low):
  - State is HUNT; sync shift register, bit counter, word counter, FIFO pointers and level are cleared.
  - All outputs are 0.
  - Reset mid-frame discards the partial word and all FIFO contents.
- HUNT:
  - shreg <= {shreg[SYNC_W-2:0], rx_bit} on every edge.
  - If {shreg[SYNC_W-2:0], rx_bit} == SYNC_PATTERN, go to DATA at that edge, with bit_cnt=0 and word_cnt=0.
- DATA:
  - Shift rx_bit into the word register (MSB first) and increment bit_cnt.
  - On the edge sampling bit DATA_W-1:
    - with PARITY_CHECK_EN, go to PARITY;
    - otherwise, push the completed word at this same edge.
- PARITY:
  - Sample the parity bit.
  - If XOR(word, parity bit) == 0, push the word.
  - Otherwise pulse parity_err for one cycle, drop the word, and go to HUNT (the frame is aborted).
- Push:
  - The FIFO entry is {last, word}, where last = (word_cnt == WORDS_PER_FRAME-1).
  - After a push, increment word_cnt. If the word was last, go to HUNT (shreg cleared); otherwise go to DATA with bit_cnt=0.
- Latency: out_valid rises immediately after the edge that pushes the word, i.e. the edge sampling the final data bit, or the parity bit when parity is enabled.
- FIFO: show-ahead.
  - out_data and out_last are driven from the head entry.
  - A pop occurs at an edge where out_valid && out_ready.
  - out_valid = (level != 0); fifo_level equals the occupancy.
- Push while full:
  - Without a simultaneous pop, the word is dropped and overflow is set to 1. The state machine still advances as if the word were pushed.
  - With a simultaneous pop, both the pop and the push occur and level is unchanged.
- Empty with out_ready high: no pop; pointers hold.
- Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Cleared by clr_ovf.
  - If clr_ovf and a new overflow event fall on the same edge, overflow stays 1 (set wins).
- The sync pattern is not searched for while in DATA or PARITY (no resync mid-frame).

Optional Feature:
- PARITY_CHECK_EN defined:
  - A single even-parity bit follows each word, and the PARITY state exists.
  - parity_err is functional.
  - Each word takes DATA_W+1 bit clocks.
- PARITY_CHECK_EN undefined:
  - No parity bit and no PARITY state.
  - parity_err is tied to 0.
  - Each word takes DATA_W bit clocks.

Test Plan:
- Sync and frame, defaults, no parity, out_ready=1: bits 0xD5, then 0x12 0x34 0x56 0x78 MSB first -> out_data shows 0x12, 0x34, 0x56, 0x78, with out_last=1 only on 0x78. locked drops after bit 40; then HUNT.
- Noise before sync: 0xAB, 0xD4, then 0xD5 and 4 words -> no output before the 0xD5 completes; the frame is decoded correctly. A 0xD5 embedded inside a payload word does not resync.
- PARITY_CHECK_EN, payload 0xA5 with parity 0 -> accepted. Payload 0xA5 with parity 1 -> parity_err pulses one cycle, no push, locked drops, and the remaining bits are hunted.
- out_ready=0, 4-word frame, FIFO_DEPTH=4 -> fifo_level=4, overflow=0. A second frame -> overflow=1 and fifo_level stays 4. Pulse clr_ovf -> overflow=0. Drain -> the first frame's words come out in order.
- Full FIFO with out_ready=1 at the push edge -> fifo_level stays 4 and overflow stays 0.
- rst_n low mid-word after 3 data bits -> all outputs 0 and state HUNT. After release, a full sync and frame decodes normally.
